sysbus_nport_arbiter: RTL
=========================

Name: sysbus_nport_arbiter

Overview:
N-client arbiter between per-client cache ports (icache, dcache, future prefetch/PTW) and the single Sysbus master port. Grants one client at a time with fixed-priority or round-robin selection, and forwards its request burst to the bus. It then routes the response burst back to the owning client only. One outstanding transaction; write requests complete without a response phase.

Parameters:
NCLIENTS, 2, number of client ports (index 0 = highest fixed priority; 0 = dcache, 1 = icache)
DATA_WIDTH, 64, bus data width
TAG_WIDTH, 13, bus tag width
RR_MODE, 1, 0 = fixed priority, 1 = round robin
RESP_BEATS, 8, response beats per read transaction
WR_TAG_BIT, 12, reqtag bit that marks a write (1 = write, no response)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cli_req  in  NCLIENTS*DATA_WIDTH  per-client request data, client i at slice i
cli_reqtag  in  NCLIENTS*TAG_WIDTH  per-client request tag
cli_reqcyc  in  NCLIENTS  client request valid, held for the whole burst
cli_reqack  out  NCLIENTS  beat accepted, one-hot to grantee
cli_resp  out  DATA_WIDTH  response data, broadcast
cli_resptag  out  TAG_WIDTH  response tag, broadcast
cli_respcyc  out  NCLIENTS  response valid, one-hot to owner
cli_respack  in  NCLIENTS  client accepts response beat
bus_req  out  DATA_WIDTH  to Sysbus
bus_reqtag  out  TAG_WIDTH  to Sysbus
bus_reqcyc  out  1  to Sysbus
bus_reqack  in  1  from Sysbus
bus_resp  in  DATA_WIDTH  from Sysbus
bus_resptag  in  TAG_WIDTH  from Sysbus
bus_respcyc  in  1  from Sysbus
bus_respack  out  1  to Sysbus
grant_id  out  $clog2(NCLIENTS) (min 1)  current owner, valid when busy=1
busy  out  1  state != IDLE
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant_id=0, rr_ptr=NCLIENTS-1, beat_cnt=0, proto_err=0. All reqack/respcyc/bus_reqcyc/bus_respack outputs = 0.
- States: IDLE, REQ, WAIT_RESP, RESP.
- IDLE: if any cli_reqcyc, register the winner into grant_id and go to REQ next cycle. Grant-to-bus latency is 1 cycle.
- Fixed mode: lowest asserted index wins. RR mode: first asserted index searching from rr_ptr+1 with wrap modulo NCLIENTS.
- REQ:
  - bus_req/reqtag/reqcyc = grantee's signals, combinational mux. cli_reqack[grant_id] = bus_reqack. All other reqacks = 0.
  - A beat transfers when bus_reqcyc & bus_reqack.
  - The grant is locked until the grantee drops reqcyc after at least one accepted beat. Then: if the latched first-beat reqtag[WR_TAG_BIT]=1, go to IDLE; otherwise go to WAIT_RESP.
  - If the grantee drops reqcyc before any ack: abandoned request, go to IDLE with no error.
- WAIT_RESP/RESP:
  - cli_respcyc[grant_id] = bus_respcyc. bus_respack = cli_respack[grant_id]. cli_resp/resptag = bus_resp/resptag.
  - First respcyc moves WAIT_RESP to RESP.
  - beat_cnt increments on respcyc & respack. When the beat with beat_cnt = RESP_BEATS-1 is acked, go to IDLE, clear beat_cnt, and set rr_ptr = grant_id.
- RR pointer also updates on write completion. It is not updated on an abandoned request.
- bus_respcyc in IDLE or REQ: not forwarded, bus_respack=0, proto_err set (cleared only by reset).
- Only bus_reqcyc is gated by state; in IDLE, bus_reqcyc=0 and bus_req/reqtag=0.
- A new arbitration happens only from IDLE, so back-to-back transactions have a 1-cycle bubble. No preemption mid-burst.
- Client requests arriving during busy are held by the client (level-sensitive); none are lost.
- Asynchronous reset mid-transaction drops everything immediately. The bus side is reset by the same reset_n.

Decomposition:
- Shared package sysbus_pkg: arb_state_t enum; the WR_TAG_BIT default; the RESP_BEATS default (8 beats x 64 b = 64 B line).
- One sub-module, rr_picker: NCLIENTS request vector plus pointer in, one-hot grant and index out, purely combinational. Fixed mode is the picker with the pointer forced to NCLIENTS-1.

Test Plan:
- Single read, client 1, tag 0x0200 -> bus_reqcyc 1 cycle after cli_reqcyc; 8 response beats seen only on cli_respcyc[1]; busy drops after the 8th ack.
- Simultaneous reqcyc on 0 and 1, RR_MODE=1, three rounds -> grants 0,1,0 with rr_ptr rotation. Same with RR_MODE=0 -> 0,0,0 while 0 keeps requesting.
- Write, reqtag bit 12=1, 9 acked beats -> returns to IDLE with no WAIT_RESP; cli_respcyc stays 0.
- Response with respack stalled 3 cycles mid-burst -> beat_cnt holds; bus_respack follows client; exactly 8 beats counted.
- bus_respcyc pulse while IDLE -> proto_err=1, bus_respack=0, no cli_respcyc; error persists until reset_n=0.
- reset_n asserted in RESP after beat 4 -> all outputs 0 asynchronously; the next request arbitrates from rr_ptr=NCLIENTS-1.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared types and defaults for the Sysbus client arbiter.
package sysbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

    // Reqtag bit that marks a write (no response phase follows).
    localparam int WR_TAG_BIT_DEF = 12;
    // 8 beats x 64 b = one 64 B cache line.
    localparam int RESP_BEATS_DEF = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sysbus_nport_arbiter_if.sv
// Client-side and Sysbus-side handshake bundle seen by the N-port arbiter.
interface sysbus_nport_arbiter_if #(
    parameter int NCLIENTS   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic [NCLIENTS*DATA_WIDTH-1:0] cli_req;
    logic [NCLIENTS*TAG_WIDTH-1:0]  cli_reqtag;
    logic [NCLIENTS-1:0]            cli_reqcyc;
    logic [NCLIENTS-1:0]            cli_reqack;
    logic [DATA_WIDTH-1:0]          cli_resp;
    logic [TAG_WIDTH-1:0]           cli_resptag;
    logic [NCLIENTS-1:0]            cli_respcyc;
    logic [NCLIENTS-1:0]            cli_respack;

    logic [DATA_WIDTH-1:0]          bus_req;
    logic [TAG_WIDTH-1:0]           bus_reqtag;
    logic                           bus_reqcyc;
    logic                           bus_reqack;
    logic [DATA_WIDTH-1:0]          bus_resp;
    logic [TAG_WIDTH-1:0]           bus_resptag;
    logic                           bus_respcyc;
    logic                           bus_respack;

    // The arbiter is the Sysbus master and the slave of every client port.
    modport master (
        input  cli_req, cli_reqtag, cli_reqcyc, cli_respack,
        input  bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        output cli_reqack, cli_resp, cli_resptag, cli_respcyc,
        output bus_req, bus_reqtag, bus_reqcyc, bus_respack
    );

    modport slave (
        output cli_req, cli_reqtag, cli_reqcyc, cli_respack,
        output bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        input  cli_reqack, cli_resp, cli_resptag, cli_respcyc,
        input  bus_req, bus_reqtag, bus_reqcyc, bus_respack
    );

endinterface

// File: rtl/sysbus_nport_arbiter_rr_picker.sv
// Combinational picker: first requester after ptr, wrapping modulo NCLIENTS.
// ptr = NCLIENTS-1 degenerates to fixed priority (lowest index wins).
module rr_picker #(
    parameter int NCLIENTS = 2,
    parameter int IDX_W    = 1
) (
    input  logic [NCLIENTS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [NCLIENTS-1:0] gnt,
    output logic [IDX_W-1:0]    idx
);

    logic [2*NCLIENTS-1:0] req2;
    logic [NCLIENTS-1:0]   rot;
    logic                  found;
    int                    cand;

    assign req2 = {req, req};

    // Rotate so bit 0 is the client right after ptr, then take the lowest set bit.
    always_comb begin
        rot   = NCLIENTS'(req2 >> (int'(ptr) + 1));
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                cand  = int'(ptr) + 1 + i;
                if (cand >= NCLIENTS) cand = cand - NCLIENTS;
                idx   = IDX_W'(cand);
                gnt   = NCLIENTS'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/sysbus_nport_arbiter.sv
// N-client arbiter onto the single Sysbus master port; one outstanding transaction.
//   state        | meaning
//   ST_IDLE      | no owner; arbitrate among asserted cli_reqcyc
//   ST_REQ       | grantee's request burst muxed onto the bus, grant locked
//   ST_WAIT_RESP | read issued, waiting for first bus_respcyc
//   ST_RESP      | response beats routed to the owner until RESP_BEATS acked
module sysbus_nport_arbiter
    import sysbus_pkg::*;
#(
    parameter  int NCLIENTS   = 2,
    parameter  int DATA_WIDTH = 64,
    parameter  int TAG_WIDTH  = 13,
    parameter  int RR_MODE    = 1,
    parameter  int RESP_BEATS = RESP_BEATS_DEF,
    parameter  int WR_TAG_BIT = WR_TAG_BIT_DEF,
    localparam int IDX_W      = idx_width(NCLIENTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sysbus_nport_arbiter_if.master bus,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int BCW = idx_width(RESP_BEATS);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     grant_nxt, rr_ptr, rr_ptr_nxt, pick_ptr, pick_idx;
    logic [NCLIENTS-1:0]  pick_gnt;
    logic [BCW-1:0]       beat_cnt, beat_nxt;
    logic                 acked, acked_nxt;
    logic                 wr_txn, wr_nxt;
    logic                 perr_nxt;

    logic [DATA_WIDTH-1:0] gnt_req;
    logic [TAG_WIDTH-1:0]  gnt_tag;
    logic                  gnt_cyc, gnt_respack;
    logic                  req_beat, resp_beat;

    logic [NCLIENTS-1:0]   reqack_v, respcyc_v;
    logic [DATA_WIDTH-1:0] bus_req_v;
    logic [TAG_WIDTH-1:0]  bus_reqtag_v;
    logic                  bus_reqcyc_v, bus_respack_v;

    assign pick_ptr = (RR_MODE != 0) ? rr_ptr : IDX_W'(NCLIENTS - 1);

    rr_picker #(
        .NCLIENTS (NCLIENTS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req (bus.cli_reqcyc),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        gnt_req     = bus.cli_req[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        gnt_tag     = bus.cli_reqtag[int'(grant_id)*TAG_WIDTH +: TAG_WIDTH];
        gnt_cyc     = bus.cli_reqcyc[grant_id];
        gnt_respack = bus.cli_respack[grant_id];
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_id;
        rr_ptr_nxt    = rr_ptr;
        beat_nxt      = beat_cnt;
        acked_nxt     = acked;
        wr_nxt        = wr_txn;
        perr_nxt      = proto_err;
        reqack_v      = '0;
        respcyc_v     = '0;
        bus_req_v     = '0;
        bus_reqtag_v  = '0;
        bus_reqcyc_v  = 1'b0;
        bus_respack_v = 1'b0;
        req_beat      = 1'b0;
        resp_beat     = 1'b0;

        // Request data/tag follow the owner outside IDLE; only reqcyc is state-gated.
        if (state != ST_IDLE) begin
            bus_req_v    = gnt_req;
            bus_reqtag_v = gnt_tag;
        end

        case (state)
            ST_IDLE: begin
                if (bus.bus_respcyc) perr_nxt = 1'b1;
                if (|pick_gnt) begin
                    grant_nxt = pick_idx;
                    acked_nxt = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bus_respcyc) perr_nxt = 1'b1;
                bus_reqcyc_v       = gnt_cyc;
                reqack_v[grant_id] = bus.bus_reqack;
                req_beat           = gnt_cyc & bus.bus_reqack;
                if (req_beat && !acked) begin
                    acked_nxt = 1'b1;
                    wr_nxt    = gnt_tag[WR_TAG_BIT];
                end
                // Burst ends when the owner drops reqcyc; no ack yet means abandoned.
                if (!gnt_cyc) begin
                    if (!acked) begin
                        state_nxt = ST_IDLE;
                    end else if (wr_txn) begin
                        state_nxt  = ST_IDLE;
                        rr_ptr_nxt = grant_id;
                    end else begin
                        state_nxt = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP, ST_RESP: begin
                respcyc_v[grant_id] = bus.bus_respcyc;
                bus_respack_v       = gnt_respack;
                resp_beat           = bus.bus_respcyc & gnt_respack;
                if (bus.bus_respcyc) state_nxt = ST_RESP;
                if (resp_beat) begin
                    if (beat_cnt == BCW'(RESP_BEATS - 1)) begin
                        beat_nxt   = '0;
                        state_nxt  = ST_IDLE;
                        rr_ptr_nxt = grant_id;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            grant_id  <= '0;
            rr_ptr    <= IDX_W'(NCLIENTS - 1);
            beat_cnt  <= '0;
            acked     <= 1'b0;
            wr_txn    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_nxt;
            acked     <= acked_nxt;
            wr_txn    <= wr_nxt;
            proto_err <= perr_nxt;
        end
    end

    assign bus.cli_reqack  = reqack_v;
    assign bus.cli_respcyc = respcyc_v;
    assign bus.cli_resp    = bus.bus_resp;
    assign bus.cli_resptag = bus.bus_resptag;
    assign bus.bus_req     = bus_req_v;
    assign bus.bus_reqtag  = bus_reqtag_v;
    assign bus.bus_reqcyc  = bus_reqcyc_v;
    assign bus.bus_respack = bus_respack_v;
    assign busy            = (state != ST_IDLE);

    a_reqack_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.cli_reqack));
    a_respcyc_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.cli_respcyc));
    a_idle_quiet: assert property (@(posedge clk) disable iff (!reset_n)
        !busy |-> (!bus.bus_reqcyc && !bus.bus_respack));

endmodule
